// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter for a single-port data memory with checked, registered responses
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h01000000,
  parameter logic [31:0] MEM_BYTES = 32'h00100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_read_write,
  input  logic [1:0]  p0_access_size,
  input  logic [31:0] p0_address,
  input  logic [31:0] p0_wdata,
  output logic        p0_rsp_valid,
  input  logic        p0_rsp_ready,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_read_write,
  input  logic [1:0]  p1_access_size,
  input  logic [31:0] p1_address,
  input  logic [31:0] p1_wdata,
  output logic        p1_rsp_valid,
  input  logic        p1_rsp_ready,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_read_write,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  logic [1:0]  full, err_q, elig, gnt, rsp_ready;
  logic [31:0] rdata [2];
  logic        last_grant, sel, any, rw, mis, oor, err, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};
  assign elig = {p1_req_valid & (~full[1] | p1_rsp_ready),
                 p0_req_valid & (~full[0] | p0_rsp_ready)};
  // reset gating keeps ready low and blocks any write while reset is held
  assign gnt[0] = reset & elig[0] & (~elig[1] | last_grant);
  assign gnt[1] = reset & elig[1] & (~elig[0] | ~last_grant);
  assign any = |gnt;
  assign sel = gnt[1];
  assign rw    = sel ? p1_read_write  : p0_read_write;
  assign size  = sel ? p1_access_size : p0_access_size;
  assign addr  = sel ? p1_address     : p0_address;
  assign wdata = sel ? p1_wdata       : p0_wdata;
  assign nbytes = size == 2'b00 ? 3'd1 : size == 2'b01 ? 3'd2 : 3'd4;
  assign mis = (size == 2'b01 & addr[0]) | (size[1] & |addr[1:0]);
  // 33-bit end address so a request near 4 GiB cannot wrap into range
  assign end_addr = {1'b0, addr} + {30'd0, nbytes};
  assign oor = (addr < BASE_ADDR) | (end_addr > ({1'b0, BASE_ADDR} + {1'b0, MEM_BYTES}));
  assign err = mis | oor;
  assign wr = any & rw & ~err;
  assign mem_read_write  = wr;
  assign mem_address     = any ? addr : BASE_ADDR;
  assign mem_access_size = any ? {size[1], size[0] & ~size[1]} : 2'b10;
  assign mem_data_in     = wr ? wdata : 32'd0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      full <= 2'b00;
      err_q <= 2'b00;
      last_grant <= 1'b1;
      for (int n = 0; n < 2; n++) rdata[n] <= 32'd0;
    end else begin
      if (any) last_grant <= sel;
      for (int n = 0; n < 2; n++)
        if (gnt[n]) begin
          full[n] <= 1'b1;
          err_q[n] <= err;
          rdata[n] <= (rw | err) ? 32'd0 : mem_data_out;
        end else if (rsp_ready[n]) full[n] <= 1'b0;
    end
  assign p0_req_ready = gnt[0];
  assign p1_req_ready = gnt[1];
  assign p0_rsp_valid = full[0];
  assign p1_rsp_valid = full[1];
  assign p0_rsp_err   = err_q[0];
  assign p1_rsp_err   = err_q[1];
  assign p0_rsp_rdata = rdata[0];
  assign p1_rsp_rdata = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a byte-level memory, a reference model and randomized two-port traffic
module tb_dmem_arbiter;
  localparam logic [31:0] BASE = 32'h01000000;
  localparam logic [31:0] MEMB = 32'h00100000;
  typedef struct { logic [31:0] d; logic e; } rsp_t;
  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;
  logic [1:0]  rv = 2'b00, rwv = 2'b00, rr = 2'b00;
  logic [1:0]  sz [2];
  logic [31:0] ad [2], wd [2];
  logic        rdy0, rdy1, val0, val1, err0, err1;
  logic [31:0] rdat0, rdat1;
  logic        mem_rw;
  logic [1:0]  mem_sz;
  logic [31:0] mem_a, mem_di, mem_do;
  logic [1:0]  qr;
  assign qr = {rdy1, rdy0};
  int total = 0, bad = 0, last = 1, g;
  logic done = 1'b0;
  rsp_t q0[$], q1[$];
  logic [7:0] rmem [logic [31:0]];
  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_req_valid(rv[0]), .p0_req_ready(rdy0), .p0_read_write(rwv[0]), .p0_access_size(sz[0]),
    .p0_address(ad[0]), .p0_wdata(wd[0]), .p0_rsp_valid(val0), .p0_rsp_ready(rr[0]),
    .p0_rsp_rdata(rdat0), .p0_rsp_err(err0),
    .p1_req_valid(rv[1]), .p1_req_ready(rdy1), .p1_read_write(rwv[1]), .p1_access_size(sz[1]),
    .p1_address(ad[1]), .p1_wdata(wd[1]), .p1_rsp_valid(val1), .p1_rsp_ready(rr[1]),
    .p1_rsp_rdata(rdat1), .p1_rsp_err(err1),
    .mem_read_write(mem_rw), .mem_access_size(mem_sz), .mem_address(mem_a),
    .mem_data_in(mem_di), .mem_data_out(mem_do)
  );
  function automatic int nb(logic [1:0] s);
    return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
  endfunction
  // the physical memory: combinational little-endian read, write on the clock edge
  logic [7:0]  mem [0:1048575];
  logic [19:0] mk;
  initial for (int i = 0; i < 1048576; i++) mem[i] <= 8'h00;
  always_comb begin
    mem_do = 32'd0;
    mk = mem_a[19:0];
    for (int i = 0; i < 4; i++)
      if (i < nb(mem_sz)) mem_do[8*i +: 8] = mem[mk + 20'(i)];
  end
  always @(posedge clock)
    if (mem_rw)
      for (int i = 0; i < 4; i++)
        if (i < nb(mem_sz)) mem[mem_a[19:0] + 20'(i)] <= mem_di[8*i +: 8];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic is_err(logic [1:0] s, logic [31:0] a);
    longint x = longint'(a);
    int b = nb(s);
    return (x % b != 0) || x < longint'(BASE) || x + b > longint'(BASE) + longint'(MEMB);
  endfunction
  function automatic logic [31:0] rref(logic [31:0] a, int b);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < b; i++)
      if (rmem.exists(a + 32'(i))) v = v | (32'(rmem[a + 32'(i)]) << (8 * i));
    return v;
  endfunction
  // issue side: predict the grant, check the bus, push the expected response at the edge
  always @(negedge clock) begin
    logic [1:0] eg;
    logic pw, pe;
    logic [1:0] ps;
    logic [31:0] pa, pd;
    rsp_t r;
    if (!reset) begin
      last = 1;
      chk("rst_req_ready", 32'(qr), 32'd0);
      chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    end else begin
      eg[0] = rv[0] && (q0.size() == 0 || rr[0]);
      eg[1] = rv[1] && (q1.size() == 0 || rr[1]);
      g = (eg == 2'b11) ? (last == 1 ? 0 : 1) : eg[0] ? 0 : eg[1] ? 1 : -1;
      chk("req_ready", 32'(qr), g < 0 ? 32'd0 : 32'(1 << g));
      pw = 1'b0; pe = 1'b0; ps = 2'b00; pa = 32'd0; pd = 32'd0;
      if (g >= 0) begin
        pw = rwv[g]; ps = sz[g]; pa = ad[g]; pd = wd[g]; pe = is_err(ps, pa);
        chk("mem_rw", 32'(mem_rw), 32'(pw && !pe));
        if (!pe) chk("mem_addr", mem_a, pa);
      end else begin
        chk("idle_mem_rw", 32'(mem_rw), 32'd0);
        chk("idle_mem_addr", mem_a, BASE);
      end
      @(posedge clock);
      if (g >= 0) begin
        r.e = pe;
        r.d = 32'd0;
        if (!pe && pw) for (int i = 0; i < nb(ps); i++) rmem[pa + 32'(i)] = pd[8*i +: 8];
        else if (!pe) r.d = rref(pa, nb(ps));
        if (g == 0) q0.push_back(r); else q1.push_back(r);
        last = g;
      end
    end
  end
  // response side: check held responses against the queue heads, pop on consumption
  always @(negedge clock) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
      chk("rst_rsp_valid", 32'({val1, val0}), 32'd0);
      chk("rst_rdata0", rdat0, 32'd0);
      chk("rst_rdata1", rdat1, 32'd0);
      chk("rst_err", 32'({err1, err0}), 32'd0);
    end else begin
      chk("rsp_valid0", 32'(val0), 32'(q0.size() > 0));
      if (val0 && q0.size() > 0) begin
        chk("rdata0", rdat0, q0[0].d);
        chk("err0", 32'(err0), 32'(q0[0].e));
        if (rr[0]) q0.delete(0);
      end
      chk("rsp_valid1", 32'(val1), 32'(q1.size() > 0));
      if (val1 && q1.size() > 0) begin
        chk("rdata1", rdat1, q1[0].d);
        chk("err1", 32'(err1), 32'(q1[0].e));
        if (rr[1]) q1.delete(0);
      end
    end
  end
  task automatic send(int p, logic w, logic [1:0] s, logic [31:0] a, logic [31:0] d);
    int n = 0;
    logic got;
    rv[p] = 1'b1; rwv[p] = w; sz[p] = s; ad[p] = a; wd[p] = d;
    forever begin
      @(negedge clock);
      got = qr[p];
      @(posedge clock);
      #1;
      if (got) break;
      if (++n > 300) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    rv[p] = 1'b0;
  endtask
  task automatic rnd_send(int p);
    logic [31:0] a;
    case ($urandom_range(0, 15))
      0: a = BASE - 32'($urandom_range(1, 8));
      1: a = BASE + MEMB - 32'($urandom_range(0, 8));
      default: a = BASE + 32'($urandom_range(0, 63));
    endcase
    send(p, 1'($urandom), 2'($urandom), a, $urandom);
  endtask
  initial begin
    sz[0] = 2'b00; sz[1] = 2'b00; ad[0] = 32'd0; ad[1] = 32'd0; wd[0] = 32'd0; wd[1] = 32'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    rr = 2'b11;
    send(0, 1'b1, 2'b10, BASE + 32'h10, 32'hDEADBEEF);
    send(0, 1'b0, 2'b10, BASE + 32'h10, 32'd0);
    send(0, 1'b0, 2'b00, BASE + 32'h11, 32'd0);
    fork
      for (int i = 0; i < 6; i++) send(0, 1'b0, 2'b10, BASE + 32'h10, 32'd0);
      for (int i = 0; i < 6; i++) send(1, 1'b0, 2'b00, BASE + 32'h12, 32'd0);
    join
    send(1, 1'b1, 2'b01, BASE + 32'h3, 32'h0000AAAA);
    send(1, 1'b0, 2'b10, BASE - 32'h4, 32'd0);
    send(1, 1'b0, 2'b10, BASE, 32'd0);
    rr[0] = 1'b0;
    fork
      begin
        send(0, 1'b0, 2'b10, BASE + 32'h10, 32'd0);
        send(0, 1'b0, 2'b00, BASE + 32'h13, 32'd0);
      end
      for (int i = 0; i < 4; i++) send(1, 1'b0, 2'b01, BASE + 32'(2 * i), 32'd0);
      begin
        repeat (8) @(posedge clock);
        #1 rr[0] = 1'b1;
      end
    join
    rr[1] = 1'b0;
    send(1, 1'b0, 2'b10, BASE + 32'h10, 32'd0);
    rv[0] = 1'b1; rwv[0] = 1'b1; sz[0] = 2'b10; ad[0] = BASE + 32'h20; wd[0] = 32'h12345678;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    rv[0] = 1'b0;
    rr = 2'b11;
    fork
      send(0, 1'b0, 2'b10, BASE + 32'h20, 32'd0);
      send(1, 1'b0, 2'b10, BASE + 32'h24, 32'd0);
    join
    send(0, 1'b1, 2'b10, BASE + MEMB - 32'h4, 32'hCAFEF00D);
    send(0, 1'b0, 2'b10, BASE + MEMB - 32'h4, 32'd0);
    send(0, 1'b0, 2'b10, BASE + MEMB - 32'h2, 32'd0);
    send(0, 1'b0, 2'b00, BASE + MEMB, 32'd0);
    send(0, 1'b0, 2'b11, BASE + MEMB - 32'h4, 32'd0);
    send(0, 1'b0, 2'b01, BASE + MEMB - 32'h2, 32'd0);
    send(0, 1'b0, 2'b00, BASE - 32'h1, 32'd0);
    fork
      begin
        fork
          for (int i = 0; i < 150; i++) rnd_send(0);
          for (int i = 0; i < 150; i++) rnd_send(1);
        join
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clock);
        #1 rr = 2'($urandom);
      end
    join
    rr = 2'b11;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
